// File: rtl/mem_stage_if.sv
// Handshake and bus signals around the memory/writeback stage.
// slave = the stage itself, master = its environment.
interface mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcod;
  logic [15:0] alu_out;
  logic        eq;
  logic [15:0] store_data;
  logic [3:0]  dest_reg;
  logic [15:0] br_target;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic        wb_we;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        br_taken;
  logic [15:0] br_pc;
  logic        err;

  modport slave (
    input  in_valid, opcod, alu_out, eq,
    input  store_data, dest_reg, br_target,
    input  mem_rdata, mem_ack,
    output in_ready, mem_req, mem_we,
    output mem_addr, mem_wdata,
    output wb_valid, wb_we, wb_reg, wb_data,
    output br_taken, br_pc, err
  );

  modport master (
    output in_valid, opcod, alu_out, eq,
    output store_data, dest_reg, br_target,
    output mem_rdata, mem_ack,
    input  in_ready, mem_req, mem_we,
    input  mem_addr, mem_wdata,
    input  wb_valid, wb_we, wb_reg, wb_data,
    input  br_taken, br_pc, err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory/writeback stage: routes ALU results to writeback,
// LW/SW to a handshaked data memory and BNE to a redirect.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_BNE = 4'hE;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    MEM_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  ld_reg_q, ld_reg_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [3:0]  wb_reg_q, wb_reg_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        br_taken_q, br_taken_d;
  logic [15:0] br_pc_q, br_pc_d;
  logic        err_q, err_d;

  logic is_alu, is_mem, is_bne;

  assign is_alu = (bus.opcod == OP_AND)
               || (bus.opcod == OP_OR)
               || (bus.opcod == OP_ADD)
               || (bus.opcod == OP_SUB)
               || (bus.opcod == OP_SLT);
  assign is_mem = (bus.opcod == OP_LW)
               || (bus.opcod == OP_SW);
  assign is_bne = (bus.opcod == OP_BNE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_reg_d    = ld_reg_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    br_taken_d  = 1'b0;
    br_pc_d     = br_pc_q;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          unique case (1'b1)
            is_alu: begin
              wb_valid_d = 1'b1;
              wb_we_d    = (bus.dest_reg != 4'd0);
              wb_reg_d   = bus.dest_reg;
              wb_data_d  = bus.alu_out;
            end
            is_mem: begin
              state_d     = MEM_WAIT;
              cnt_d       = 8'd0;
              mem_req_d   = 1'b1;
              mem_we_d    = (bus.opcod == OP_SW);
              mem_addr_d  = bus.alu_out;
              mem_wdata_d = bus.store_data;
              ld_reg_d    = bus.dest_reg;
            end
            is_bne: begin
              br_taken_d = ~bus.eq;
              br_pc_d    = bus.br_target;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      MEM_WAIT: begin
        // ack is checked first so it wins over a same-cycle timeout
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            wb_valid_d = 1'b1;
            wb_we_d    = (ld_reg_q != 4'd0);
            wb_reg_d   = ld_reg_q;
            wb_data_d  = bus.mem_rdata;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 16'd0;
      ld_reg_q    <= 4'd0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_reg_q    <= 4'd0;
      wb_data_q   <= 16'd0;
      br_taken_q  <= 1'b0;
      br_pc_q     <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_reg_q    <= ld_reg_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      br_taken_q  <= br_taken_d;
      br_pc_q     <= br_pc_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_we     = wb_we_q;
  assign bus.wb_reg    = wb_reg_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.br_taken  = br_taken_q;
  assign bus.br_pc     = br_pc_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reference model compared every
// cycle plus literal expectations along the directed sequence.
module tb_mem_stage;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  mem_stage_if bus();

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Reference model: tracks one outstanding access as a record.
  logic        m_ready, m_req, m_we;
  logic [15:0] m_addr, m_wdata;
  logic        m_wbv, m_wbwe;
  logic [3:0]  m_wbreg;
  logic [15:0] m_wbdata;
  logic        m_br;
  logic [15:0] m_brpc;
  logic        m_err;
  bit          p_busy, p_load;
  logic [3:0]  p_reg;
  int          p_waited;

  task automatic m_writeback(input logic [3:0] r,
                             input logic [15:0] d);
    m_wbv    = 1'b1;
    m_wbreg  = r;
    m_wbdata = d;
    m_wbwe   = (r != 4'd0);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready = 1; m_req = 0; m_we = 0;
      m_addr = 0; m_wdata = 0;
      m_wbv = 0; m_wbwe = 0; m_wbreg = 0; m_wbdata = 0;
      m_br = 0; m_brpc = 0; m_err = 0;
      p_busy = 0; p_load = 0; p_reg = 0; p_waited = 0;
    end else begin
      m_wbv = 0; m_wbwe = 0; m_br = 0; m_err = 0;
      if (!p_busy) begin
        if (bus.in_valid) begin
          case (bus.opcod)
            4'h0, 4'h1, 4'h2, 4'h6, 4'h7:
              m_writeback(bus.dest_reg, bus.alu_out);
            4'h8, 4'hA: begin
              p_busy   = 1;
              p_load   = (bus.opcod == 4'h8);
              p_reg    = bus.dest_reg;
              p_waited = 0;
              m_req    = 1;
              m_we     = !p_load;
              m_addr   = bus.alu_out;
              m_wdata  = bus.store_data;
            end
            4'hE: begin
              m_br   = !bus.eq;
              m_brpc = bus.br_target;
            end
            default: m_err = 1;
          endcase
        end
      end else if (bus.mem_ack) begin
        p_busy = 0;
        m_req  = 0;
        if (p_load) m_writeback(p_reg, bus.mem_rdata);
      end else begin
        p_waited++;
        if (p_waited == TO) begin
          p_busy = 0;
          m_req  = 0;
          m_err  = 1;
        end
      end
      m_ready = !p_busy;
    end
  end

  always @(negedge clk) begin
    if (run && !rst) begin
      check("in_ready", 32'(bus.in_ready), 32'(m_ready));
      check("mem_req", 32'(bus.mem_req), 32'(m_req));
      if (m_req) begin
        check("mem_we", 32'(bus.mem_we), 32'(m_we));
        check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        check("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
      end
      check("wb_valid", 32'(bus.wb_valid), 32'(m_wbv));
      if (m_wbv) begin
        check("wb_we", 32'(bus.wb_we), 32'(m_wbwe));
        check("wb_reg", 32'(bus.wb_reg), 32'(m_wbreg));
        check("wb_data", 32'(bus.wb_data), 32'(m_wbdata));
      end else begin
        check("wb_we_idle", 32'(bus.wb_we), 32'd0);
      end
      check("br_taken", 32'(bus.br_taken), 32'(m_br));
      if (m_br) check("br_pc", 32'(bus.br_pc), 32'(m_brpc));
      check("err", 32'(bus.err), 32'(m_err));
    end
  end

  // Inputs change 2 time units after the active edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [15:0] a,
                       input logic [3:0] rd);
    bus.in_valid = 1'b1;
    bus.opcod    = op;
    bus.alu_out  = a;
    bus.dest_reg = rd;
  endtask

  initial begin
    bus.in_valid   = 0;
    bus.opcod      = 0;
    bus.alu_out    = 0;
    bus.eq         = 0;
    bus.store_data = 0;
    bus.dest_reg   = 0;
    bus.br_target  = 0;
    bus.mem_rdata  = 0;
    bus.mem_ack    = 0;
    rst = 1;
    step();
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst mem_req", 32'(bus.mem_req), 32'd0);
    check("rst wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst err", 32'(bus.err), 32'd0);
    check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    step();
    rst = 0;
    run = 1;

    // ALU stream, second write targets r0
    issue(4'h2, 16'h1234, 4'd3);
    step();
    check("add wb_valid", 32'(bus.wb_valid), 32'd1);
    check("add wb_reg", 32'(bus.wb_reg), 32'd3);
    check("add wb_data", 32'(bus.wb_data), 32'h1234);
    check("add wb_we", 32'(bus.wb_we), 32'd1);
    issue(4'h6, 16'hFFFF, 4'd0);
    step();
    check("sub wb_valid", 32'(bus.wb_valid), 32'd1);
    check("sub wb_we r0", 32'(bus.wb_we), 32'd0);
    check("sub wb_data", 32'(bus.wb_data), 32'hFFFF);
    bus.in_valid = 0;
    step();
    check("alu pulse end", 32'(bus.wb_valid), 32'd0);

    // LW acked in its third request cycle
    issue(4'h8, 16'h0040, 4'd5);
    step();
    bus.in_valid = 0;
    check("lw mem_req", 32'(bus.mem_req), 32'd1);
    check("lw mem_addr", 32'(bus.mem_addr), 32'h0040);
    check("lw in_ready", 32'(bus.in_ready), 32'd0);
    step();
    step();
    check("lw hold addr", 32'(bus.mem_addr), 32'h0040);
    bus.mem_ack   = 1;
    bus.mem_rdata = 16'hBEEF;
    step();
    bus.mem_ack = 0;
    check("lw wb_valid", 32'(bus.wb_valid), 32'd1);
    check("lw wb_reg", 32'(bus.wb_reg), 32'd5);
    check("lw wb_data", 32'(bus.wb_data), 32'hBEEF);
    check("lw req drop", 32'(bus.mem_req), 32'd0);
    check("lw in_ready", 32'(bus.in_ready), 32'd1);

    // SW acked in first request cycle
    issue(4'hA, 16'h0010, 4'd2);
    bus.store_data = 16'hA5A5;
    step();
    bus.in_valid = 0;
    check("sw mem_we", 32'(bus.mem_we), 32'd1);
    check("sw mem_wdata", 32'(bus.mem_wdata), 32'hA5A5);
    check("sw mem_addr", 32'(bus.mem_addr), 32'h0010);
    bus.mem_ack = 1;
    step();
    bus.mem_ack = 0;
    check("sw no wb", 32'(bus.wb_valid), 32'd0);
    check("sw in_ready", 32'(bus.in_ready), 32'd1);

    // BNE taken, then not taken
    issue(4'hE, 16'h0000, 4'd0);
    bus.eq        = 0;
    bus.br_target = 16'h0100;
    step();
    check("bne taken", 32'(bus.br_taken), 32'd1);
    check("bne pc", 32'(bus.br_pc), 32'h0100);
    bus.eq = 1;
    step();
    bus.in_valid = 0;
    check("bne eq", 32'(bus.br_taken), 32'd0);
    check("bne no wb", 32'(bus.wb_valid), 32'd0);

    // LW never acked
    issue(4'h8, 16'h0080, 4'd6);
    step();
    bus.in_valid = 0;
    repeat (3) step();
    check("to pre err", 32'(bus.err), 32'd0);
    check("to pre req", 32'(bus.mem_req), 32'd1);
    step();
    check("to err", 32'(bus.err), 32'd1);
    check("to req low", 32'(bus.mem_req), 32'd0);
    check("to no wb", 32'(bus.wb_valid), 32'd0);
    bus.mem_ack   = 1;
    bus.mem_rdata = 16'h1111;
    step();
    bus.mem_ack = 0;
    check("late ack wb", 32'(bus.wb_valid), 32'd0);
    check("late ack err", 32'(bus.err), 32'd0);

    // illegal opcode
    issue(4'h3, 16'h5555, 4'd4);
    step();
    bus.in_valid = 0;
    check("ill err", 32'(bus.err), 32'd1);
    check("ill no wb", 32'(bus.wb_valid), 32'd0);
    step();
    check("ill err end", 32'(bus.err), 32'd0);

    // async reset while waiting on memory
    issue(4'h8, 16'h0200, 4'd7);
    step();
    bus.in_valid = 0;
    step();
    check("ar req", 32'(bus.mem_req), 32'd1);
    #1 rst = 1;
    #1;
    check("ar mem_req", 32'(bus.mem_req), 32'd0);
    check("ar mem_addr", 32'(bus.mem_addr), 32'd0);
    check("ar in_ready", 32'(bus.in_ready), 32'd1);
    check("ar wb_reg", 32'(bus.wb_reg), 32'd0);
    #2 rst = 0;
    bus.mem_ack   = 1;
    bus.mem_rdata = 16'h2222;
    step();
    bus.mem_ack = 0;
    check("ar stale ack", 32'(bus.wb_valid), 32'd0);
    issue(4'h0, 16'h00F0, 4'd9);
    step();
    bus.in_valid = 0;
    check("ar alu wb", 32'(bus.wb_valid), 32'd1);
    check("ar alu reg", 32'(bus.wb_reg), 32'd9);
    check("ar alu data", 32'(bus.wb_data), 32'h00F0);
    repeat (3) step();

    run = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
